// File: rtl/section_event_profiler.sv
// Section event profiler: per-metric global and per-section counters. Sections are paced by a
// reference metric, and section records drain from a FWFT FIFO over a valid/ready stream.

module section_event_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         inc,
    input  logic         close,
    output logic [W-1:0] sec_next,
    output logic         sec_sat_next,
    output logic [W-1:0] total,
    output logic         total_sat
);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] sec;
    logic         sec_sat;

    // An event saturates the counter when it is all-ones or one below it,
    // so "top" ignores the LSB.
    assign sec_next     = (inc && !(&sec)) ? sec + ONE : sec;
    assign sec_sat_next = sec_sat | (inc & (&sec[W-1:1]));

    always_ff @(posedge clk) begin
        if (flush) begin
            sec       <= '0;
            sec_sat   <= 1'b0;
            total     <= '0;
            total_sat <= 1'b0;
        end else begin
            if (close) begin
                sec     <= '0;
                sec_sat <= 1'b0;
            end else begin
                sec     <= sec_next;
                sec_sat <= sec_sat_next;
            end
            if (inc && !(&total))
                total <= total + ONE;
            if (inc && (&total[W-1:1]))
                total_sat <= 1'b1;
        end
    end
endmodule

module section_event_profiler #(
    parameter int N_METRICS         = 13,
    parameter int COUNTER_WIDTH     = 32,
    parameter int SECTION_CNT_WIDTH = 10,
    parameter int FIFO_DEPTH        = 4,
    parameter int REF_METRIC        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable_i,
    input  logic                                 clear_i,
    input  logic                                 eop_i,
    input  logic [N_METRICS-1:0]                 events_i,
    input  logic [SECTION_CNT_WIDTH-1:0]         section_len_i,
    output logic                                 rec_valid_o,
    input  logic                                 rec_ready_i,
    output logic [N_METRICS*COUNTER_WIDTH-1:0]   rec_counters_o,
    output logic [N_METRICS-1:0]                 rec_sat_o,
    output logic [15:0]                          rec_index_o,
    output logic                                 rec_last_o,
    output logic [N_METRICS*COUNTER_WIDTH-1:0]   total_counters_o,
    output logic [N_METRICS-1:0]                 total_sat_o,
    output logic [15:0]                          dropped_o,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SECTION_CNT_WIDTH-1:0] SONE     = 1;
    localparam logic [AW-1:0]                PONE     = 1;
    localparam logic [AW:0]                  LONE     = 1;
    localparam logic [AW:0]                  FULL_LVL = FIFO_DEPTH;

    typedef struct packed {
        logic [N_METRICS-1:0][COUNTER_WIDTH-1:0] cnt;
        logic [N_METRICS-1:0]                    sat;
        logic [15:0]                             idx;
        logic                                    last;
    } rec_t;

    typedef enum logic {COUNT, DONE} state_t;

    state_t state, state_nxt;

    logic                                    flush, counting, ref_ev, boundary, push, push_ok, pop, full;
    logic [N_METRICS-1:0]                    inc, sec_sat_next;
    logic [N_METRICS-1:0][COUNTER_WIDTH-1:0] sec_next, total;
    logic [SECTION_CNT_WIDTH-1:0]            ref_q, len_q, ref_nxt;
    logic [15:0]                             idx_q;
    logic [AW-1:0]                           wr_ptr, rd_ptr;
    logic [AW:0]                             level;
    rec_t                                    mem [FIFO_DEPTH];
    rec_t                                    wr_rec, head;

    assign flush    = rst | clear_i;
    assign counting = (state == COUNT) & enable_i;
    assign inc      = {N_METRICS{counting}} & events_i;
    assign ref_ev   = counting & events_i[REF_METRIC];
    assign ref_nxt  = ref_q + SONE;
    // Modulo compare: len_q == 0 closes after 2^SECTION_CNT_WIDTH reference events.
    assign boundary = ref_ev & (ref_nxt == len_q);
    assign push     = (state == COUNT) & (boundary | eop_i);

    for (genvar g = 0; g < N_METRICS; g++) begin : g_lane
        section_event_lane #(.W(COUNTER_WIDTH)) u_lane (
            .clk          (clk),
            .flush        (flush),
            .inc          (inc[g]),
            .close        (boundary),
            .sec_next     (sec_next[g]),
            .sec_sat_next (sec_sat_next[g]),
            .total        (total[g]),
            .total_sat    (total_sat_o[g])
        );
    end

    assign total_counters_o = total;

    always_comb begin
        state_nxt = state;
        if (state == COUNT && eop_i)
            state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (flush) state <= COUNT;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            ref_q     <= '0;
            len_q     <= section_len_i;
            idx_q     <= '0;
            dropped_o <= '0;
        end else begin
            if (boundary) begin
                ref_q <= '0;
                idx_q <= idx_q + 16'd1;
                len_q <= section_len_i;
            end else if (ref_ev) begin
                ref_q <= ref_nxt;
            end
            if (push && !push_ok && dropped_o != 16'hFFFF)
                dropped_o <= dropped_o + 16'd1;
        end
    end

    // Record FIFO: a full FIFO still accepts a push when the head pops in the same cycle.
    assign full        = (level == FULL_LVL);
    assign rec_valid_o = (level != '0);
    assign pop         = rec_valid_o & rec_ready_i;
    assign push_ok     = push & (~full | pop);

    always_comb begin
        wr_rec      = '0;
        wr_rec.cnt  = sec_next;
        wr_rec.sat  = sec_sat_next;
        wr_rec.idx  = idx_q;
        wr_rec.last = eop_i;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PONE;
            if (pop)     rd_ptr <= rd_ptr + PONE;
            if (push_ok && !pop)      level <= level + LONE;
            else if (!push_ok && pop) level <= level - LONE;
        end
    end

    assign head           = mem[rd_ptr];
    assign fifo_level_o   = level;
    assign rec_counters_o = rec_valid_o ? head.cnt  : '0;
    assign rec_sat_o      = rec_valid_o ? head.sat  : '0;
    assign rec_index_o    = rec_valid_o ? head.idx  : '0;
    assign rec_last_o     = rec_valid_o ? head.last : 1'b0;
endmodule
